// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf
//
// Registered 1-to-2 demultiplexer. One valid/ready input stream carries a
// word plus a select bit. Each word is steered into one of two output
// channels. Each channel has a single holding register with its own
// valid/ready handshake, so the two consumers stall independently of each
// other. Each channel also has a wrapping counter of delivered words.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake
//   in_data, in_sel        input word and destination (0 -> ch0, 1 -> ch1)
//   out0_valid/out0_ready  channel 0 handshake, out0_data channel 0 word
//   out1_valid/out1_ready  channel 1 handshake, out1_data channel 1 word
//   cnt0, cnt1             words delivered per channel, mod 2^CNT_W

module demux_1to2_buf #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             vld0, vld1;
  logic [WIDTH-1:0] reg0, reg1;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  logic sel_vld, sel_rdy;
  logic acc, acc0, acc1;
  logic drain0, drain1;

  // in_ready looks only at the selected channel. A full channel can still
  // accept a word when its consumer drains in the same cycle, which gives
  // one word per cycle of throughput.
  always_comb begin
    sel_vld  = in_sel ? vld1 : vld0;
    sel_rdy  = in_sel ? out1_ready : out0_ready;
    in_ready = ~sel_vld | sel_rdy;
    acc      = in_valid & in_ready;
    acc0     = acc & ~in_sel;
    acc1     = acc & in_sel;
    drain0   = vld0 & out0_ready;
    drain1   = vld1 & out1_ready;
  end

  // Channel 0. An accept wins over a drain for vld. This keeps the register
  // full when the old word leaves and a new word arrives on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0   <= 1'b0;
      reg0   <= '0;
      cnt0_q <= '0;
    end else begin
      vld0 <= acc0 | (vld0 & ~drain0);
      if (acc0) reg0 <= in_data;
      if (drain0) cnt0_q <= cnt0_q + CNT_ONE;
    end
  end

  // Channel 1. This mirrors channel 0 and is fully independent of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1   <= 1'b0;
      reg1   <= '0;
      cnt1_q <= '0;
    end else begin
      vld1 <= acc1 | (vld1 & ~drain1);
      if (acc1) reg1 <= in_data;
      if (drain1) cnt1_q <= cnt1_q + CNT_ONE;
    end
  end

  assign out0_valid = vld0;
  assign out0_data  = reg0;
  assign out1_valid = vld1;
  assign out1_data  = reg1;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf
//
// Self-checking bench for demux_1to2_buf. Stimulus is driven on the falling
// edge. Expected words are pushed to a per-channel queue on accept. They are
// popped and compared when the consumer side completes a handshake.

module tb_demux_1to2_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] out1_data;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  demux_1to2_buf #(.WIDTH(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [7:0]  m_cnt0;
  logic [7:0]  m_cnt1;
  logic [7:0]  m_acc;
  logic        last_accept;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Run one clock cycle with the given inputs. The bench predicts handshakes
  // from its own model, and updates the scoreboard and counters.
  task automatic applyStimulus(input logic v, input logic s, input logic [15:0] d,
                               input logic r0, input logic r1);
    logic        exp_rdy;
    logic [15:0] exp_word;
    logic [7:0]  sum;
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    checkOutput("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    checkOutput("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    exp_rdy = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (q0.size() != 0 && r0) begin
      exp_word = q0.pop_front();
      checkOutput("out0_data", 32'(out0_data), 32'(exp_word));
      m_cnt0 = m_cnt0 + 8'd1;
    end
    if (q1.size() != 0 && r1) begin
      exp_word = q1.pop_front();
      checkOutput("out1_data", 32'(out1_data), 32'(exp_word));
      m_cnt1 = m_cnt1 + 8'd1;
    end
    if (v && exp_rdy) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
      m_acc = m_acc + 8'd1;
      last_accept = 1'b1;
    end else begin
      last_accept = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("cnt0", 32'(cnt0), 32'(m_cnt0));
    checkOutput("cnt1", 32'(cnt1), 32'(m_cnt1));
    sum = cnt0 + cnt1 + 8'(out0_valid) + 8'(out1_valid);
    checkOutput("conservation", 32'(sum), 32'(m_acc));
  endtask

  // Assert reset between clock edges. Reset values must show at once,
  // without waiting for a clock edge.
  task automatic resetDut();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out0_valid", 32'(out0_valid), 32'd0);
    checkOutput("rst_out1_valid", 32'(out1_valid), 32'd0);
    checkOutput("rst_out0_data", 32'(out0_data), 32'd0);
    checkOutput("rst_out1_data", 32'(out1_data), 32'd0);
    checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
    checkOutput("rst_cnt1", 32'(cnt1), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    q0.delete();
    q1.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
    m_acc  = '0;
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_hold_out0_valid", 32'(out0_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        p_v;
  logic        p_s;
  logic [15:0] p_d;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    m_cnt0     = '0;
    m_cnt1     = '0;
    m_acc      = '0;
    last_accept = 1'b0;
    #12;
    rst_n = 1'b1;

    // Fill both channels, then reset while they are full.
    applyStimulus(1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hF0F0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    resetDut();

    // Basic steer.
    applyStimulus(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("steer_cnt0", 32'(cnt0), 32'd1);
    checkOutput("steer_cnt1", 32'(cnt1), 32'd1);

    // Backpressure isolation.
    applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp_out0_held", 32'(out0_data), 32'h1111);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Pass-through at full rate on channel 1.
    resetDut();
    for (int i = 1; i <= 16; i++)
      applyStimulus(1'b1, 1'b1, 16'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("pass_cnt1", 32'(cnt1), 32'd16);

    // Counter wrap on channel 0.
    resetDut();
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b1, 1'b0, 16'(i * 3 + 7), 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("wrap_cnt0", 32'(cnt0), 32'd0);
    checkOutput("wrap_cnt1", 32'(cnt1), 32'd0);

    // Random soak. The producer holds a word until it is accepted.
    p_v = 1'b0;
    p_s = 1'b0;
    p_d = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!p_v || last_accept) begin
        p_v = ($urandom_range(0, 3) != 0);
        p_s = 1'($urandom_range(0, 1));
        p_d = 16'($urandom);
      end
      applyStimulus(p_v, p_s, p_d, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
